// File: rtl/keypad_pkg.sv
// Shared keypad constants and key-index helpers.
package keypad_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_COLS = 4;

    // Lowest set bit wins, so simultaneous keys resolve to the smallest index.
    function automatic logic [KEY_W-1:0] low_idx(input logic [15:0] v);
        low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) low_idx = KEY_W'(i);
        end
    endfunction

    // {column one-hot, row one-hot} of the lowest pressed key, zero when idle.
    function automatic logic [7:0] note_enc(input logic [15:0] v);
        logic [KEY_W-1:0] idx;
        idx = low_idx(v);
        if (v == '0) note_enc = '0;
        else         note_enc = {4'b0001 << idx[3:2], 4'b0001 << idx[1:0]};
    endfunction

endpackage

// File: rtl/keypad_colscan.sv
// Row synchroniser plus column divider/driver; samp marks the last cycle of a column period.
// Latency: rows reach row_hit two cycles after the pins; no backpressure.
module keypad_colscan #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [1:0] col_idx,
    output logic       samp,
    output logic [3:0] row_hit
);
    import keypad_pkg::*;

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       row_s1, row_s2;
    logic [DIV_W-1:0] div;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1  <= 4'hF;
            row_s2  <= 4'hF;
            div     <= '0;
            col     <= 4'b1110;
            col_idx <= 2'd0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            if (div == DIV_LAST) begin
                div     <= '0;
                col     <= {col[2:0], col[3]};
                col_idx <= col_idx + 2'd1;
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    assign samp    = (div == DIV_LAST);
    assign row_hit = ~row_s2;

endmodule

// File: rtl/keypad_scan_db.sv
// 4x4 keypad scanner: frame debounce, press events with valid/ack handshake and sticky overflow.
// Latency: event and note_vec one cycle after debounced changes; an unacked pending event drops new ones.
// Optional KEYPAD_TYPEMATIC_EN adds periodic repeat events while exactly one key is held.
module keypad_scan_db #(
    parameter int SCAN_DIV      = 1000,
    parameter int DB_COUNT      = 4,
    parameter int REPEAT_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_ovf,
    output logic [7:0] note_vec
);
    import keypad_pkg::*;

    localparam logic [3:0] DB_LIM = 4'(DB_COUNT);

    logic             samp;
    logic [1:0]       col_idx;
    logic [3:0]       row_hit;
    logic [15:0]      snapshot, snap_prev, debounced, deb_d, snap_new, press;
    logic [3:0]       stable_cnt, cnt_nxt;
    logic             frame_end, evt, rep_pend;
    logic [KEY_W-1:0] evt_code;

    keypad_colscan #(.SCAN_DIV(SCAN_DIV)) u_colscan (
        .clk     (clk),
        .rst     (rst),
        .row     (row),
        .col     (col),
        .col_idx (col_idx),
        .samp    (samp),
        .row_hit (row_hit)
    );

    always_comb begin
        snap_new = snapshot;
        snap_new[{col_idx, 2'b00} +: 4] = row_hit;
        frame_end = samp && (col_idx == 2'd3);
        if (snap_new != snap_prev)  cnt_nxt = '0;
        else if (stable_cnt == DB_LIM) cnt_nxt = DB_LIM;
        else                        cnt_nxt = stable_cnt + 4'd1;
        press    = debounced & ~deb_d;
        evt      = (press != '0) || rep_pend;
        evt_code = (press != '0) ? low_idx(press) : low_idx(debounced);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot   <= '0;
            snap_prev  <= '0;
            debounced  <= '0;
            deb_d      <= '0;
            stable_cnt <= '0;
            key_code   <= '0;
            key_valid  <= 1'b0;
            key_ovf    <= 1'b0;
            note_vec   <= '0;
        end else begin
            deb_d    <= debounced;
            note_vec <= note_enc(debounced);
            if (samp) snapshot <= snap_new;
            if (frame_end) begin
                snap_prev  <= snap_new;
                stable_cnt <= cnt_nxt;
                if (cnt_nxt == DB_LIM) debounced <= snap_new;
            end
            if (evt) begin
                if (!key_valid || key_ack) begin
                    key_code  <= evt_code;
                    key_valid <= 1'b1;
                end else begin
                    key_ovf <= 1'b1;
                end
            end else if (key_ack && key_valid) begin
                key_valid <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_TYPEMATIC_EN
    localparam int               REP_W    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             deb_chg;

    assign deb_chg = (cnt_nxt == DB_LIM) && (snap_new != debounced);

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt  <= '0;
            rep_pend <= 1'b0;
        end else begin
            rep_pend <= 1'b0;
            if (frame_end) begin
                if (deb_chg || !$onehot(debounced)) begin
                    rep_cnt <= '0;
                end else if (rep_cnt == REP_LAST) begin
                    rep_cnt  <= '0;
                    rep_pend <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + REP_W'(1);
                end
            end
        end
    end
`else
    // Repeats disabled; the comparison is constant-false for any legal REPEAT_FRAMES.
    assign rep_pend = (REPEAT_FRAMES < 0);
`endif

endmodule

// File: doc/keypad_scan_db.md
KEYPAD_SCAN_DB -- requirements
Module: keypad_scan_db

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clk cycles each column is driven before its rows are sampled (min 4).
REQ-002 SHALL have parameter DB_COUNT, default 4, consecutive identical frames beyond the first required to accept a new key state (1..15).
REQ-003 SHALL have parameter REPEAT_FRAMES, default 64, frames between typematic repeats (used only under REQ-026).
REQ-004 clk  in  1  single clock; one clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 row  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-007 col  out  4  column drive, active-low one-hot.
REQ-008 key_code  out  4  index of reported key, col_idx*4 + row_idx.
REQ-009 key_valid  out  1  key event pending.
REQ-010 key_ack  in  1  consumer accepts pending event.
REQ-011 key_ovf  out  1  sticky flag, event lost.
REQ-012 note_vec  out  8  {col one-hot, row one-hot} of lowest-index debounced pressed key, 0 if none; drives wavegen diods input.

Function
REQ-013 row SHALL pass a two-flop synchroniser before any use.
REQ-014 A divider SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it samples inverted synchronised row into the 4 snapshot bits of the current column, then advances col (0->1->2->3->0).
REQ-015 One frame = 4 column periods = 4*SCAN_DIV cycles; frame end is the sample of column 3.
REQ-016 At frame end: snapshot equal to previous snapshot -> stable_cnt increments, saturating at DB_COUNT; otherwise stable_cnt <= 0; previous snapshot <= snapshot.
REQ-017 When stable_cnt equals DB_COUNT after the update, debounced[15:0] <= snapshot.
REQ-018 Press event = bit set in new debounced, clear in old; simultaneous new presses report only the lowest index, others silently dropped.
REQ-019 Releases SHALL generate no event.
REQ-020 Event with key_valid=0, or key_valid=1 and key_ack=1 same cycle: key_code loaded, key_valid=1 next cycle.
REQ-021 Event with key_valid=1 and key_ack=0: event dropped, key_ovf set, key_code unchanged.
REQ-022 key_ack with key_valid=1 and no event clears key_valid next cycle; key_ack with key_valid=0 ignored.
REQ-023 note_vec registered, updates cycle after debounced changes.

Reset
REQ-024 rst SHALL set: divider 0, col=4'b1110, snapshots/debounced 0, stable_cnt 0, key_code 0, key_valid 0, key_ovf 0, note_vec 0, synchroniser flops 1.
REQ-025 rst mid-frame SHALL abandon the partial frame; first full frame after rst starts at column 0.

Configuration
REQ-026 With KEYPAD_TYPEMATIC_EN defined: while debounced has exactly one bit set, a repeat counter counts frames; each REPEAT_FRAMES frames emits a press event for that key via REQ-020/021; counter clears on any debounced change. Without it: no repeat counter, no repeats.

Structure
REQ-027 Shared package keypad_pkg SHALL hold key index width (4), column count (4), and note_vec encoding function.
REQ-028 Synchroniser + divider/column driver SHALL be sub-module keypad_colscan; debounce, event and handshake logic in keypad_scan_db.

Verification (SCAN_DIV=4, DB_COUNT=3, REPEAT_FRAMES=2; frame=16 cycles)
REQ-029 Key 6 (col 1, row 2) held clean from frame 0 -> key_valid=1, key_code=6, note_vec=8'b0010_0100 one cycle after end of frame 3; nothing earlier.
REQ-030 Key 6 bouncing every 5 cycles for 2 frames then steady -> exactly one event, 4 steady frames after bounce ends.
REQ-031 Keys 3 and 9 pressed same frame -> single event key_code=3; note_vec=8'b0001_1000.
REQ-032 Event pending, no ack, second key pressed -> key_ovf=1, key_code unchanged; ack in event cycle -> new code loaded, key_ovf stays 0.
REQ-033 rst asserted mid-column 2 while key held -> all outputs reset values next cycle, col=4'b1110, event re-reported 4 frames later.
REQ-034 KEYPAD_TYPEMATIC_EN, key 0 held, acks immediate -> events every 2 frames after first; undefined -> one event only.
